// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the mem_responder slice (state encoding,
// bus word/byte-enable types, latency ceiling and the alignment check).
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } memresp_state_t;

    typedef logic [3:0]  mem_be_t;
    typedef logic [31:0] mem_word_t;

    localparam int MEM_MAX_LATENCY = 15;

    // Legal lane patterns are byte, halfword and word, shifted to the byte offset.
    function automatic logic be_legal(input logic [1:0] off, input mem_be_t be);
        logic ok;
        case (off)
            2'd0:    ok = (be == 4'b0001) || (be == 4'b0011) || (be == 4'b1111);
            2'd1:    ok = (be == 4'b0010) || (be == 4'b0110);
            2'd2:    ok = (be == 4'b0100) || (be == 4'b1100);
            2'd3:    ok = (be == 4'b1000);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic misaligned(input logic [1:0] off, input logic we, input mem_be_t be);
        return (off != 2'b00) || (we && !be_legal(off, be));
    endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Word storage M for mem_responder: synchronous byte-enabled write port and
// asynchronous read of the same index. Contents are never reset.
module mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] idx,
    input  mem_be_t          be,
    input  mem_word_t        wdata,
    output mem_word_t        rdata
);

    mem_word_t M [DEPTH_WORDS];

    // Byte-lane write of the enabled lanes only
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    M[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = M[idx];

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory target: one request at a time, response after LATENCY
// wait cycles. Optional misalignment error via MEM_RESPONDER_MISALIGN_CHECK_EN.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int LAT_C = (LATENCY > MEM_MAX_LATENCY) ? MEM_MAX_LATENCY : LATENCY;
    localparam logic [3:0] LAT_LOAD = (LAT_C > 0) ? 4'(LAT_C - 1) : 4'd0;
    localparam bit ZERO_LAT = (LAT_C == 0);

    memresp_state_t state_r, state_nx_s;
    logic [3:0]  cnt_r;
    logic [31:0] addr_r;
    logic        we_r;
    mem_be_t     be_r;
    mem_word_t   wdata_r;
    logic        resp_valid_r;
    mem_word_t   rdata_r;
    logic        err_r;

    logic        commit_s;
    logic        req_ready_s;
    logic        accept_s;
    logic [31:0] acc_addr_s;
    logic        acc_we_s;
    mem_be_t     acc_be_s;
    mem_word_t   acc_wdata_s;
    logic        err_s;
    logic        wr_en_s;
    mem_word_t   rd_s;
    logic        unused_addr_s;

    // Next-state decode; the commit strobe marks the edge that enters RESP
    always_comb begin
        state_nx_s  = state_r;
        commit_s    = 1'b0;
        req_ready_s = 1'b0;
        case (state_r)
            IDLE: begin
                req_ready_s = 1'b1;
                if (req_valid) begin
                    if (ZERO_LAT) begin
                        state_nx_s = RESP;
                        commit_s   = 1'b1;
                    end else begin
                        state_nx_s = WAIT;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nx_s = RESP;
                    commit_s   = 1'b1;
                end else begin
                    state_nx_s = WAIT;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    assign accept_s  = (state_r == IDLE) && req_valid;
    assign req_ready = req_ready_s;

    // Zero latency commits on the accept edge, before the request is latched
    assign acc_addr_s  = (state_r == IDLE) ? req_addr  : addr_r;
    assign acc_we_s    = (state_r == IDLE) ? req_we    : we_r;
    assign acc_be_s    = (state_r == IDLE) ? req_be    : be_r;
    assign acc_wdata_s = (state_r == IDLE) ? req_wdata : wdata_r;

`ifdef MEM_RESPONDER_MISALIGN_CHECK_EN
    assign err_s = misaligned(acc_addr_s[1:0], acc_we_s, acc_be_s);
`else
    assign err_s = 1'b0;
`endif

    assign unused_addr_s = ^{acc_addr_s[31:IDX_W+2], acc_addr_s[1:0]};
    assign wr_en_s = commit_s && acc_we_s && !err_s && !reset;

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk  (clk),
        .wr_en(wr_en_s),
        .idx  (acc_addr_s[IDX_W+1:2]),
        .be   (acc_be_s),
        .wdata(acc_wdata_s),
        .rdata(rd_s)
    );

    // State, request latch and wait counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            addr_r  <= 32'd0;
            we_r    <= 1'b0;
            be_r    <= 4'd0;
            wdata_r <= 32'd0;
        end else begin
            state_r <= state_nx_s;
            if (accept_s) begin
                addr_r  <= req_addr;
                we_r    <= req_we;
                be_r    <= req_be;
                wdata_r <= req_wdata;
                cnt_r   <= LAT_LOAD;
            end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Registered response; held until the initiator takes it
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_r <= 1'b0;
            rdata_r      <= 32'd0;
            err_r        <= 1'b0;
        end else if (commit_s) begin
            resp_valid_r <= 1'b1;
            rdata_r      <= (acc_we_s || err_s) ? 32'd0 : rd_s;
            err_r        <= err_s;
        end else if ((state_r == RESP) && resp_ready) begin
            resp_valid_r <= 1'b0;
            rdata_r      <= 32'd0;
            err_r        <= 1'b0;
        end else begin
            resp_valid_r <= resp_valid_r;
            rdata_r      <= rdata_r;
            err_r        <= err_r;
        end
    end

    assign resp_valid = resp_valid_r;
    assign resp_rdata = rdata_r;
    assign resp_err   = err_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: three instances (LATENCY 2, 4, 0) share
// the request bus; a vector table plus backpressure and reset-mid-WAIT sequences.
module tb_mem_responder;

`ifdef MEM_RESPONDER_MISALIGN_CHECK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    localparam int LAT0 = 2;
    localparam int LAT1 = 4;
    localparam int LAT2 = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] req_addr;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic [2:0]  req_valid;
    logic [2:0]  resp_ready;
    logic [2:0]  req_ready;
    logic [2:0]  resp_valid;
    logic [2:0]  resp_err;
    logic [31:0] resp_rdata [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT0)) u_l2 (
        .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr), .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

    mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT1)) u_l4 (
        .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr), .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

    mem_responder #(.DEPTH_WORDS(1024), .LATENCY(LAT2)) u_l0 (
        .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_addr(req_addr), .req_we(req_we), .req_be(req_be), .req_wdata(req_wdata),
        .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
        .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

    typedef struct {
        int          k;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input int k);
        return (k == 0) ? LAT0 + 1 : (k == 1) ? LAT1 + 1 : LAT2 + 1;
    endfunction

    // One full transaction on instance k, with optional backpressure cycles
    task automatic txn(input string name, input int k, input logic [31:0] a, input logic we,
                       input logic [3:0] be, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input int hold);
        int  lat;
        bit  rdy_low;
        @(negedge clk);
        req_addr = a; req_we = we; req_be = be; req_wdata = wd;
        req_valid[k] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        req_addr = a ^ 32'h0000_0FF4; req_we = ~we; req_be = ~be; req_wdata = ~wd;
        lat = 0;
        rdy_low = 1'b1;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (req_ready[k]) rdy_low = 1'b0;
            if (resp_valid[k]) break;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat(k)));
        check({name, " req_ready low"}, {31'd0, rdy_low}, 32'd1);
        check({name, " rdata"}, resp_rdata[k], exp_rd);
        check({name, " err"}, {31'd0, resp_err[k]}, {31'd0, exp_err});
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({name, " hold valid"}, {31'd0, resp_valid[k]}, 32'd1);
            check({name, " hold rdata"}, resp_rdata[k], exp_rd);
        end
        resp_ready[k] = 1'b1;
        @(negedge clk);
        resp_ready[k] = 1'b0;
        check({name, " idle ready"}, {31'd0, req_ready[k]}, 32'd1);
        check({name, " idle valid"}, {31'd0, resp_valid[k]}, 32'd0);
    endtask

    initial begin
        logic [31:0] m1_l2;
        logic [31:0] m1_l0;
        logic [31:0] m2_l0;
        int          seen;

        m1_l2 = MIS ? 32'hAABBCCDD : 32'hAA22CC44;
        m2_l0 = MIS ? 32'h00000000 : 32'h0000AB00;
        m1_l0 = MIS ? 32'h1234BEEF : 32'h12AA55EF;
        vecs[0]  = '{0, 32'h0000000C, 1'b0, 4'h0, 32'h0,        32'h00108093, 1'b0};
        vecs[1]  = '{0, 32'h00000004, 1'b1, 4'h5, 32'h11223344, 32'h0,        MIS};
        vecs[2]  = '{0, 32'h00000004, 1'b0, 4'h0, 32'h0,        m1_l2,        1'b0};
        vecs[3]  = '{0, 32'h00001000, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[4]  = '{0, 32'h00000000, 1'b0, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[5]  = '{0, 32'h00000004, 1'b1, 4'h0, 32'hFFFFFFFF, 32'h0,        MIS};
        vecs[6]  = '{0, 32'h00000004, 1'b0, 4'h0, 32'h0,        m1_l2,        1'b0};
        vecs[7]  = '{2, 32'h00000004, 1'b0, 4'h0, 32'h0,        32'h12345678, 1'b0};
        vecs[8]  = '{2, 32'h00000006, 1'b0, 4'h0, 32'h0,        MIS ? 32'h0 : 32'h12345678, MIS};
        vecs[9]  = '{2, 32'h00000009, 1'b1, 4'h2, 32'h0000AB00, 32'h0,        MIS};
        vecs[10] = '{2, 32'h00000008, 1'b0, 4'h0, 32'h0,        m2_l0,        1'b0};
        vecs[11] = '{2, 32'h00000004, 1'b1, 4'h3, 32'h0000BEEF, 32'h0,        1'b0};
        vecs[12] = '{2, 32'h00000004, 1'b0, 4'h0, 32'h0,        32'h1234BEEF, 1'b0};
        vecs[13] = '{2, 32'h00000004, 1'b1, 4'h6, 32'h00AA5500, 32'h0,        MIS};
        vecs[14] = '{2, 32'h00000004, 1'b0, 4'h0, 32'h0,        m1_l0,        1'b0};
        vecs[15] = '{1, 32'h00000010, 1'b0, 4'h0, 32'h0,        32'hCAFEF00D, 1'b0};

        reset = 1'b1;
        req_valid = 3'b000; resp_ready = 3'b000;
        req_addr = 32'd0; req_we = 1'b0; req_be = 4'd0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset%0d req_ready", k), {31'd0, req_ready[k]}, 32'd1);
            check($sformatf("reset%0d resp_valid", k), {31'd0, resp_valid[k]}, 32'd0);
            check($sformatf("reset%0d rdata", k), resp_rdata[k], 32'd0);
            check($sformatf("reset%0d err", k), {31'd0, resp_err[k]}, 32'd0);
        end

        u_l2.u_array.M[3] = 32'h00108093;
        u_l2.u_array.M[1] = 32'hAABBCCDD;
        u_l2.u_array.M[0] = 32'h00000000;
        u_l0.u_array.M[1] = 32'h12345678;
        u_l0.u_array.M[2] = 32'h00000000;
        u_l4.u_array.M[4] = 32'hCAFEF00D;
        u_l4.u_array.M[2] = 32'h55555555;

        for (int i = 0; i < 16; i++) begin
            txn($sformatf("vec%0d", i), vecs[i].k, vecs[i].addr, vecs[i].we, vecs[i].be,
                vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err, 0);
        end
        check("wrap M[0]", u_l2.u_array.M[0], 32'hDEADBEEF);

        txn("backpressure", 0, 32'h0000000C, 1'b0, 4'h0, 32'h0, 32'h00108093, 1'b0, 5);

        // Reset while a write waits on the LATENCY=4 instance
        @(negedge clk);
        req_addr = 32'h00000008; req_we = 1'b1; req_be = 4'hF; req_wdata = 32'h0;
        req_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        check("midwait ready low", {31'd0, req_ready[1]}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("postreset ready", {31'd0, req_ready[1]}, 32'd1);
        check("postreset valid", {31'd0, resp_valid[1]}, 32'd0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (resp_valid[1]) seen++;
        end
        check("postreset no resp", 32'(seen), 32'd0);
        check("postreset M[2]", u_l4.u_array.M[2], 32'h55555555);
        txn("postreset read", 1, 32'h00000008, 1'b0, 4'h0, 32'h0, 32'h55555555, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
